// File: rtl/lab4_branch_update_ctrl.sv
// Update-queue controller in front of the gshare predictor: arbitrates two update sources
// into a FIFO and time-shares the predictor PC port. Stats via LAB4_BRANCH_UPDATE_CTRL_STATS_EN.
module lab4_branch_update_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_AGE    = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          lkup_val,
   output logic                          lkup_rdy,
   input  logic [31:0]                   lkup_pc,
   output logic                          lkup_pred,
   input  logic                          upd0_val,
   output logic                          upd0_rdy,
   input  logic [31:0]                   upd0_pc,
   input  logic                          upd0_taken,
   input  logic                          upd1_val,
   output logic                          upd1_rdy,
   input  logic [31:0]                   upd1_pc,
   input  logic                          upd1_taken,
   output logic                          bp_update_en,
   output logic                          bp_update_val,
   output logic [31:0]                   bp_pc,
   input  logic                          bp_prediction,
`ifdef LAB4_BRANCH_UPDATE_CTRL_STATS_EN
   output logic [31:0]                   stat_lkup_stall,
   output logic [31:0]                   stat_force_entries,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(MAX_AGE + 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] AGE_MAX_C = AW'(MAX_AGE);

   typedef enum logic {S_LKUP, S_FORCE} state_t;

   state_t        state;
   state_t        state_next;

   logic [31:0]   pc_mem [FIFO_DEPTH];
   logic          tk_mem [FIFO_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW-1:0] force_cnt;
   logic [CW-1:0] force_cnt_next;
   logic [AW-1:0] age;
   logic [AW-1:0] age_next;
   logic          rr;
   logic          grant0;
   logic          grant1;
   logic          full;
   logic          empty;
   logic          enq;
   logic          drain;
   logic [31:0]   enq_pc;
   logic          enq_tk;

   // Enqueue arbitration: ready is withheld on a full queue even if it drains this cycle
   always_comb begin
      full     = (count == DEPTH_C);
      empty    = (count == '0);
      grant0   = upd0_val & (~upd1_val | ~rr);
      grant1   = upd1_val & (~upd0_val | rr);
      upd0_rdy = grant0 & ~full;
      upd1_rdy = grant1 & ~full;
      enq      = (grant0 | grant1) & ~full;
      enq_pc   = grant1 ? upd1_pc : upd0_pc;
      enq_tk   = grant1 ? upd1_taken : upd0_taken;
   end

   always_comb begin
      count_next     = count + CW'(enq) - CW'(drain);
      force_cnt_next = force_cnt + CW'(drain);
      if (drain || empty)
         age_next = '0;
      else if (age == AGE_MAX_C)
         age_next = age;
      else
         age_next = age + AW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         age       <= '0;
         rr        <= 1'b0;
         force_cnt <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PW'(1);
            rr   <= grant0;
         end
         if (drain)
            head <= head + PW'(1);
         count     <= count_next;
         age       <= age_next;
         force_cnt <= (state == S_FORCE && state_next == S_FORCE) ? force_cnt_next : '0;
      end
   end

   // Queue payload storage carries no reset; occupancy alone defines validity
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[tail] <= enq_pc;
         tk_mem[tail] <= enq_tk;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_LKUP;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_LKUP: begin
            if (count_next == DEPTH_C || age_next == AGE_MAX_C)
               state_next = S_FORCE;
         end
         S_FORCE: begin
            // The drain limit caps how long lookups can be stalled per visit
            if (count_next == '0 || force_cnt_next == DEPTH_C)
               state_next = S_LKUP;
         end
         default: state_next = S_LKUP;
      endcase
   end

   always_comb begin
      lkup_rdy      = (state == S_LKUP);
      drain         = ~empty & ((state == S_FORCE) | ~lkup_val);
      bp_update_en  = drain;
      bp_update_val = drain & tk_mem[head];
      bp_pc         = drain ? pc_mem[head] : lkup_pc;
      lkup_pred     = bp_prediction;
      fifo_count    = count;
   end

`ifdef LAB4_BRANCH_UPDATE_CTRL_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_lkup_stall    <= '0;
         stat_force_entries <= '0;
      end else begin
         if (lkup_val & ~lkup_rdy)
            stat_lkup_stall <= stat_lkup_stall + 32'd1;
         if (state == S_LKUP && state_next == S_FORCE)
            stat_force_entries <= stat_force_entries + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lab4_branch_update_ctrl.sv
// Testbench for lab4_branch_update_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_lab4_branch_update_ctrl;

   localparam int DEPTH = 4;
   localparam int AGE   = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lkup_val, lkup_rdy, lkup_pred;
   logic [31:0] lkup_pc;
   logic        upd0_val, upd0_rdy, upd0_taken;
   logic [31:0] upd0_pc;
   logic        upd1_val, upd1_rdy, upd1_taken;
   logic [31:0] upd1_pc;
   logic        bp_update_en, bp_update_val, bp_prediction;
   logic [31:0] bp_pc;
   logic [2:0]  fifo_count;
`ifdef LAB4_BRANCH_UPDATE_CTRL_STATS_EN
   logic [31:0] stat_lkup_stall, stat_force_entries;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic        tk;
   } ent_t;

   ent_t mq[$];
   int   m_age;
   bit   m_force;
   int   m_drained;
   int   m_rr;

   lab4_branch_update_ctrl #(.FIFO_DEPTH(DEPTH), .MAX_AGE(AGE)) dut (
      .clk(clk), .reset(reset),
      .lkup_val(lkup_val), .lkup_rdy(lkup_rdy), .lkup_pc(lkup_pc), .lkup_pred(lkup_pred),
      .upd0_val(upd0_val), .upd0_rdy(upd0_rdy), .upd0_pc(upd0_pc), .upd0_taken(upd0_taken),
      .upd1_val(upd1_val), .upd1_rdy(upd1_rdy), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
      .bp_update_en(bp_update_en), .bp_update_val(bp_update_val), .bp_pc(bp_pc),
      .bp_prediction(bp_prediction),
`ifdef LAB4_BRANCH_UPDATE_CTRL_STATS_EN
      .stat_lkup_stall(stat_lkup_stall), .stat_force_entries(stat_force_entries),
`endif
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lkup_val = 0; lkup_pc = 0; bp_prediction = 0;
      upd0_val = 0; upd0_pc = 0; upd0_taken = 0;
      upd1_val = 0; upd1_pc = 0; upd1_taken = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mq.delete();
      m_age = 0; m_force = 0; m_drained = 0; m_rr = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      #2;
      checks++;
      if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      checks++;
      if (bp_update_en !== 1'b0) begin failures++; $display("FAIL reset_upd_en got=%b exp=0", bp_update_en); end
`ifdef LAB4_BRANCH_UPDATE_CTRL_STATS_EN
      checks++;
      if (stat_lkup_stall !== 32'd0 || stat_force_entries !== 32'd0) begin
         failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_lkup_stall, stat_force_entries);
      end
`endif
      tick();
      reset = 1'b0;
      #4;
      checks++;
      if (lkup_rdy !== 1'b1) begin failures++; $display("FAIL reset_lkup_rdy got=%b exp=1", lkup_rdy); end
      tick();
   endtask

   task automatic test_lookup();
      do_reset();
      lkup_val = 1; lkup_pc = 32'h100; bp_prediction = 1;
      #4;
      checks++;
      if (lkup_rdy !== 1'b1) begin failures++; $display("FAIL lookup_rdy got=%b exp=1", lkup_rdy); end
      checks++;
      if (lkup_pred !== 1'b1) begin failures++; $display("FAIL lookup_pred got=%b exp=1", lkup_pred); end
      checks++;
      if (bp_pc !== 32'h100) begin failures++; $display("FAIL lookup_bp_pc got=%h exp=100", bp_pc); end
      checks++;
      if (bp_update_en !== 1'b0) begin failures++; $display("FAIL lookup_upd_en got=%b exp=0", bp_update_en); end
      tick();
      lkup_pc = 32'hdeadbeec; bp_prediction = 0;
      #4;
      checks++;
      if (lkup_pred !== 1'b0 || bp_pc !== 32'hdeadbeec) begin
         failures++; $display("FAIL lookup2 got pred=%b pc=%h exp pred=0 pc=deadbeec", lkup_pred, bp_pc);
      end
      tick();
   endtask

   task automatic test_opportunistic();
      do_reset();
      lkup_val = 0; upd0_val = 1; upd0_pc = 32'h200; upd0_taken = 1;
      #4;
      checks++;
      if (upd0_rdy !== 1'b1) begin failures++; $display("FAIL opp_upd0_rdy got=%b exp=1", upd0_rdy); end
      checks++;
      if (bp_update_en !== 1'b0) begin failures++; $display("FAIL opp_no_bypass got=%b exp=0", bp_update_en); end
      tick();
      upd0_val = 0;
      #4;
      checks++;
      if (bp_update_en !== 1'b1 || bp_pc !== 32'h200 || bp_update_val !== 1'b1) begin
         failures++; $display("FAIL opp_drain got en=%b pc=%h val=%b exp en=1 pc=200 val=1", bp_update_en, bp_pc, bp_update_val);
      end
      checks++;
      if (fifo_count !== 3'd1) begin failures++; $display("FAIL opp_count1 got=%0d exp=1", fifo_count); end
      tick();
      #4;
      checks++;
      if (fifo_count !== 3'd0 || bp_update_en !== 1'b0) begin
         failures++; $display("FAIL opp_after got count=%0d en=%b exp 0/0", fifo_count, bp_update_en);
      end
      tick();
   endtask

   task automatic test_fill_force();
      logic [31:0] exp_pc [4];
      logic        exp_tk [4];
      do_reset();
      lkup_val = 1; lkup_pc = 32'h500; upd0_val = 1; upd1_val = 1;
      upd0_taken = 1; upd1_taken = 0;
      for (int i = 0; i < 4; i++) begin
         upd0_pc = 32'h1000 + i;
         upd1_pc = 32'h2000 + i;
         exp_pc[i] = (i % 2 == 0) ? upd0_pc : upd1_pc;
         exp_tk[i] = (i % 2 == 0);
         #4;
         checks++;
         if (upd0_rdy !== (i % 2 == 0) || upd1_rdy !== (i % 2 == 1)) begin
            failures++; $display("FAIL fill_grant%0d got rdy0=%b rdy1=%b exp=%0d", i, upd0_rdy, upd1_rdy, i % 2);
         end
         checks++;
         if (fifo_count !== 3'(i) || lkup_rdy !== 1'b1) begin
            failures++; $display("FAIL fill_count%0d got count=%0d rdy=%b exp=%0d/1", i, fifo_count, lkup_rdy, i);
         end
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         #4;
         if (j == 0) begin
            checks++;
            if (fifo_count !== 3'd4 || upd0_rdy !== 1'b0 || upd1_rdy !== 1'b0) begin
               failures++; $display("FAIL fill_full got count=%0d rdy0=%b rdy1=%b exp 4/0/0", fifo_count, upd0_rdy, upd1_rdy);
            end
            upd0_val = 0; upd1_val = 0;
         end
         checks++;
         if (lkup_rdy !== 1'b0 || bp_update_en !== 1'b1) begin
            failures++; $display("FAIL force%0d got rdy=%b en=%b exp 0/1", j, lkup_rdy, bp_update_en);
         end
         checks++;
         if (bp_pc !== exp_pc[j] || bp_update_val !== exp_tk[j]) begin
            failures++; $display("FAIL force_order%0d got pc=%h val=%b exp pc=%h val=%b", j, bp_pc, bp_update_val, exp_pc[j], exp_tk[j]);
         end
         tick();
      end
      #4;
      checks++;
      if (lkup_rdy !== 1'b1 || bp_update_en !== 1'b0 || fifo_count !== 3'd0) begin
         failures++; $display("FAIL force_exit got rdy=%b en=%b count=%0d exp 1/0/0", lkup_rdy, bp_update_en, fifo_count);
      end
`ifdef LAB4_BRANCH_UPDATE_CTRL_STATS_EN
      checks++;
      if (stat_force_entries !== 32'd1 || stat_lkup_stall !== 32'd4) begin
         failures++; $display("FAIL stats got entries=%0d stall=%0d exp 1/4", stat_force_entries, stat_lkup_stall);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (stat_force_entries !== 32'd0 || stat_lkup_stall !== 32'd0) begin
         failures++; $display("FAIL stats_reset got entries=%0d stall=%0d exp 0/0", stat_force_entries, stat_lkup_stall);
      end
      reset = 1'b0;
`endif
      tick();
   endtask

   task automatic test_aging();
      do_reset();
      lkup_val = 1; lkup_pc = 32'h700; upd1_val = 1; upd1_pc = 32'h300; upd1_taken = 0;
      #4;
      checks++;
      if (upd1_rdy !== 1'b1) begin failures++; $display("FAIL age_accept got=%b exp=1", upd1_rdy); end
      tick();
      upd1_val = 0;
      for (int k = 1; k <= 10; k++) begin
         #4;
         checks++;
         if (bp_update_en !== (k == 9) || lkup_rdy !== (k != 9)) begin
            failures++; $display("FAIL age_cycle%0d got en=%b rdy=%b exp en=%b", k, bp_update_en, lkup_rdy, k == 9);
         end
         if (k == 9) begin
            checks++;
            if (bp_pc !== 32'h300 || bp_update_val !== 1'b0) begin
               failures++; $display("FAIL age_payload got pc=%h val=%b exp 300/0", bp_pc, bp_update_val);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_in_force();
      do_reset();
      lkup_val = 1; upd0_val = 1;
      for (int i = 0; i < 4; i++) begin
         upd0_pc = 32'h800 + i;
         tick();
      end
      upd0_val = 0;
      tick();
      #1;
      checks++;
      if (fifo_count !== 3'd3 || lkup_rdy !== 1'b0) begin
         failures++; $display("FAIL rf_setup got count=%0d rdy=%b exp 3/0", fifo_count, lkup_rdy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bp_update_en !== 1'b0 || fifo_count !== 3'd0) begin
         failures++; $display("FAIL rf_async got en=%b count=%0d exp 0/0", bp_update_en, fifo_count);
      end
      tick();
      tick();
      reset = 1'b0;
      lkup_val = 0;
      for (int k = 0; k < 6; k++) begin
         #4;
         checks++;
         if (bp_update_en !== 1'b0 || lkup_rdy !== 1'b1) begin
            failures++; $display("FAIL rf_after%0d got en=%b rdy=%b exp 0/1", k, bp_update_en, lkup_rdy);
         end
         tick();
      end
   endtask

   task automatic test_random();
      ent_t e;
      int   g, sz;
      bit   e_drain, had;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         lkup_val      = ($urandom_range(0, 9) < ((c < 300) ? 8 : 4));
         lkup_pc       = $urandom;
         bp_prediction = 1'($urandom_range(0, 1));
         upd0_val      = ($urandom_range(0, 2) == 0);
         upd1_val      = ($urandom_range(0, 2) == 0);
         upd0_pc       = $urandom; upd0_taken = 1'($urandom_range(0, 1));
         upd1_pc       = $urandom; upd1_taken = 1'($urandom_range(0, 1));
         sz      = mq.size();
         e_drain = (sz > 0) && (m_force || !lkup_val);
         if (upd0_val && upd1_val) g = m_rr;
         else if (upd0_val)        g = 0;
         else if (upd1_val)        g = 1;
         else                      g = -1;
         #4;
         checks++;
         if (lkup_rdy !== !m_force || bp_update_en !== e_drain) begin
            failures++; $display("FAIL rnd_ctrl c=%0d got rdy=%b en=%b exp rdy=%b en=%b", c, lkup_rdy, bp_update_en, !m_force, e_drain);
         end
         checks++;
         if (upd0_rdy !== (g == 0 && sz < DEPTH) || upd1_rdy !== (g == 1 && sz < DEPTH)) begin
            failures++; $display("FAIL rnd_updrdy c=%0d got %b%b exp grant=%0d size=%0d", c, upd0_rdy, upd1_rdy, g, sz);
         end
         checks++;
         if (fifo_count !== 3'(sz)) begin
            failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fifo_count, sz);
         end
         checks++;
         if (e_drain && (bp_pc !== mq[0].pc || bp_update_val !== mq[0].tk)) begin
            failures++; $display("FAIL rnd_drain c=%0d got pc=%h val=%b exp pc=%h val=%b", c, bp_pc, bp_update_val, mq[0].pc, mq[0].tk);
         end else if (!e_drain && (bp_pc !== lkup_pc || lkup_pred !== bp_prediction)) begin
            failures++; $display("FAIL rnd_lookup c=%0d got pc=%h pred=%b exp pc=%h pred=%b", c, bp_pc, lkup_pred, lkup_pc, bp_prediction);
         end
         had = (sz > 0);
         if (e_drain) void'(mq.pop_front());
         if (g >= 0 && sz < DEPTH) begin
            e.pc = (g == 0) ? upd0_pc : upd1_pc;
            e.tk = (g == 0) ? upd0_taken : upd1_taken;
            mq.push_back(e);
            m_rr = 1 - g;
         end
         m_age = (e_drain || !had) ? 0 : ((m_age < AGE) ? m_age + 1 : AGE);
         if (!m_force) begin
            if (mq.size() == DEPTH || m_age == AGE) begin
               m_force = 1; m_drained = 0;
            end
         end else begin
            m_drained += int'(e_drain);
            if (mq.size() == 0 || m_drained == DEPTH) m_force = 0;
         end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_lookup();
      test_opportunistic();
      test_fill_force();
      test_aging();
      test_reset_in_force();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
